// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, a sign-fix cycle, and a result held until the CDB accepts its tag.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  SrcA,
  input  logic [XLEN-1:0]  SrcB,
  input  logic [TAG_W-1:0] Tag_in,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             ready,
  output logic             result_valid,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] Tag_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              neg_q, neg_d;        // product / quotient must be negated
  logic              rem_neg_q, rem_neg_d; // remainder takes the dividend's sign
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Issue-side decode of the incoming operands.
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_overflow;
  logic [XLEN-1:0] special_res;

  assign a_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sign_a   = a_signed & SrcA[XLEN-1];
  assign sign_b   = b_signed & SrcB[XLEN-1];
  assign a_mag    = sign_a ? -SrcA : SrcA;
  assign b_mag    = sign_b ? -SrcB : SrcB;

  assign div_by_zero  = op[2] && (SrcB == '0);
  assign div_overflow = ((op == OP_DIV) || (op == OP_REM)) &&
                        (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  assign special_res  = div_by_zero ? (op[1] ? SrcA : '1)
                                    : (op[1] ? '0   : SrcA);

  // One multiply step: conditionally add the multiplicand into the high half, shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_mag_q} : '0);
  assign mul_next = {mul_sum, p_q[XLEN-1:1]};

  // One restoring-divide step: {remainder, dividend/quotient} shifts left one bit.
  logic [XLEN:0]     div_trial, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  assign div_trial = p_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, b_mag_q};
  assign div_ok    = ~div_diff[XLEN];
  assign div_next  = {div_ok ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0], p_q[XLEN-2:0], div_ok};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem, fix_res;
  assign prod_fix = neg_q ? -p_q : p_q;
  assign quot     = p_q[XLEN-1:0];
  assign rem      = p_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL:                    fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011:    fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:            fix_res = neg_q ? -quot : quot;
      default:                   fix_res = rem_neg_q ? -rem : rem;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_d      = op;
          tag_d     = Tag_in;
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          a_mag_d   = a_mag;
          b_mag_d   = b_mag;
          p_d       = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          cnt_d     = CNT_W'(XLEN - 1);
          if (div_by_zero || div_overflow) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
        CALC: begin
          p_d   = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          result_d = fix_res;
          state_d  = DONE;
        end
        DONE: if (cdb_valid && (cdb_tag == tag_q)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are reset, as the outputs must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      tag_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign Tag_out      = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): arithmetic, special cases,
// latency, CDB hold/release, flush and asynchronous reset.
module tb_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op;
  logic [XLEN-1:0]  SrcA, SrcB;
  logic [TAG_W-1:0] Tag_in;
  logic             flush;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             ready, result_valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] Tag_out;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .Tag_in       (Tag_in),
    .flush        (flush),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .ready        (ready),
    .result_valid (result_valid),
    .result       (result),
    .Tag_out      (Tag_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue at a negedge; the following posedge is edge 1 (the one that samples start).
  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] t);
    op = o; SrcA = a; SrcB = b; Tag_in = t; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_tag(input string name, input logic [TAG_W-1:0] t);
    cdb_valid = 1'b1; cdb_tag = t;
    @(posedge clk);
    @(negedge clk);
    cdb_valid = 1'b0;
    check({name, "_rel_valid"}, 64'(result_valid), 64'd0);
    check({name, "_rel_ready"}, 64'(ready), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                        input logic [XLEN-1:0] exp, input int exp_lat);
    int n;
    bit ready_seen;
    issue(o, a, b, t);
    n = 1;
    ready_seen = 1'b0;
    while (!result_valid && n < 200) begin
      if (ready) ready_seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_ready_low"}, 64'(ready_seen), 64'd0);
    check({name, "_result"}, 64'(result), 64'(exp));
    check({name, "_tag"}, 64'(Tag_out), 64'(t));
    release_tag(name, t);
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start = 1'b0; op = '0; SrcA = '0; SrcB = '0; Tag_in = '0;
    flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
    #1;
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(Tag_out), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Multiply family
    run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 4'd3, 32'hFFFF_FFEB, 34);
    run_op("mulh",     3'b001, 32'd7,        32'hFFFF_FFFD, 4'd4, 32'hFFFF_FFFF, 34);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFE, 34);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'hFFFF_FFFF, 34);
    run_op("mulhsu_p", 3'b010, 32'd2,        32'd3,         4'd7, 32'd0,         34);

    // Divide family
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         4'd1, 32'hFFFF_FFFD, 34);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         4'd2, 32'hFFFF_FFFF, 34);
    run_op("rem_negb", 3'b110, 32'd7,        32'hFFFF_FFFE, 4'd8, 32'd1,         34);
    run_op("divu",     3'b101, 32'h8000_0000, 32'd3,         4'd9, 32'h2AAA_AAAA, 34);
    run_op("remu",     3'b111, 32'h8000_0000, 32'd3,         4'hA, 32'd2,         34);

    // Special cases resolved at issue
    run_op("div_z",    3'b100, 32'd5,        32'd0,         4'hB, 32'hFFFF_FFFF, 1);
    run_op("remu_z",   3'b111, 32'd5,        32'd0,         4'hC, 32'd5,         1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'hD, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'hE, 32'd0,         1);

    // Hold: mismatched CDB tags and a stray start must not disturb the held result
    issue(3'b000, 32'd3, 32'd5, 4'd5);
    for (int i = 0; i < 60 && !result_valid; i++) @(negedge clk);
    check("hold_valid0", 64'(result_valid), 64'd1);
    cdb_valid = 1'b1; cdb_tag = 4'd6;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        op = 3'b000; SrcA = 32'd9; SrcB = 32'd9; Tag_in = 4'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0; cdb_valid = 1'b0;
    check("hold_result", 64'(result), 64'd15);
    check("hold_tag", 64'(Tag_out), 64'd5);
    check("hold_valid", 64'(result_valid), 64'd1);
    check("hold_ready", 64'(ready), 64'd0);
    release_tag("hold", 4'd5);
    run_op("after_hold", 3'b000, 32'd3, 32'd4, 4'd7, 32'd12, 34);

    // Flush at iteration 10
    issue(3'b000, 32'd6, 32'd7, 4'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 64'(ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op("after_flush", 3'b000, 32'd3, 32'd4, 4'd3, 32'd12, 34);

    // Asynchronous reset at iteration 20
    issue(3'b000, 32'd6, 32'd7, 4'd4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(result_valid), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_tag", 64'(Tag_out), 64'd0);
    check("arst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op("after_rst", 3'b000, 32'd3, 32'd4, 4'd1, 32'd12, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
